// File: rtl/fib_pkg.sv
// rtl/fib_pkg.sv - shared Fibonacci types and constants for the generator and index finder.
package fib_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } fib_state_t;

  // Largest n with F(n) < 2^32; the search for an all-ones target ends here.
  localparam int F_MAX_INDEX_W32 = 47;

  localparam int F_ZERO = 0;
  localparam int F_ONE  = 1;

endpackage

// File: rtl/fib_index_finder_if.sv
// rtl/fib_index_finder_if.sv - request/result bundle for fib_index_finder (FIB_INDEX_FINDER_FLOOR_EN adds floor/remainder).
interface fib_index_finder_if #(
  parameter int W  = 32,
  parameter int NW = 16
);

  logic          start;
  logic [W-1:0]  target;
  logic          busy;
  logic          done;
  logic [NW-1:0] n;
  logic          exact;
`ifdef FIB_INDEX_FINDER_FLOOR_EN
  logic [W-1:0]  fib_floor;
  logic [W-1:0]  remainder;

  modport master (output start, target, input busy, done, n, exact, fib_floor, remainder);
  modport slave  (input start, target, output busy, done, n, exact, fib_floor, remainder);
`else
  modport master (output start, target, input busy, done, n, exact);
  modport slave  (input start, target, output busy, done, n, exact);
`endif

endinterface

// File: rtl/fib_step.sv
// rtl/fib_step.sv - registered Fibonacci advance: (a, b, idx) -> (b, a+b, idx+1).
module fib_step
  import fib_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          init,
  input  logic          adv,
  output logic [W:0]    a,
  output logic [W:0]    b,
  output logic [NW-1:0] idx
);

  localparam int WA = W + 1;

  // One extra bit keeps F(48) and F(49) from wrapping at W=32.
  always_ff @(posedge clk) begin
    if (reset) begin
      a   <= '0;
      b   <= '0;
      idx <= '0;
    end else if (init) begin
      a   <= WA'(F_ZERO);
      b   <= WA'(F_ONE);
      idx <= '0;
    end else if (adv) begin
      a   <= b;
      b   <= a + b;
      idx <= idx + NW'(1);
    end
  end

endmodule

// File: rtl/fib_index_finder.sv
// rtl/fib_index_finder.sv - finds largest n with F(n) <= target, one step per clock.
// Optional floor/remainder outputs under FIB_INDEX_FINDER_FLOOR_EN.
module fib_index_finder
  import fib_pkg::*;
#(
  parameter int W  = 32,
  parameter int NW = 16
) (
  input  logic              clk,
  input  logic              reset,
  fib_index_finder_if.slave bus
);

  fib_state_t    state;
  logic [W-1:0]  tgt;
  logic [W:0]    tgt_ext;
  logic [W:0]    a;
  logic [W:0]    b;
  logic [NW-1:0] idx;
  logic          init;
  logic          adv;

  assign tgt_ext = {1'b0, tgt};
  assign init    = (state == IDLE) && bus.start;
  assign adv     = (state == RUN) && (a < tgt_ext);

  fib_step #(
    .W  (W),
    .NW (NW)
  ) u_step (
    .clk   (clk),
    .reset (reset),
    .init  (init),
    .adv   (adv),
    .a     (a),
    .b     (b),
    .idx   (idx)
  );

`ifdef FIB_INDEX_FINDER_FLOOR_EN
  // On overshoot a=F(idx), b=F(idx+1), so the floor value F(idx-1) is b-a.
  logic [W:0] prev;
  assign prev = b - a;
`else
  logic unused_b;
  assign unused_b = ^b;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      tgt       <= '0;
      bus.busy  <= 1'b0;
      bus.done  <= 1'b0;
      bus.n     <= '0;
      bus.exact <= 1'b0;
`ifdef FIB_INDEX_FINDER_FLOOR_EN
      bus.fib_floor <= '0;
      bus.remainder <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          bus.done <= 1'b0;
          if (bus.start) begin
            tgt      <= bus.target;
            bus.busy <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          if (a == tgt_ext) begin
            bus.n     <= idx;
            bus.exact <= 1'b1;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
`ifdef FIB_INDEX_FINDER_FLOOR_EN
            bus.fib_floor <= tgt;
            bus.remainder <= '0;
`endif
          end else if (a > tgt_ext) begin
            bus.n     <= idx - NW'(1);
            bus.exact <= 1'b0;
            bus.busy  <= 1'b0;
            bus.done  <= 1'b1;
            state     <= DONE;
`ifdef FIB_INDEX_FINDER_FLOOR_EN
            bus.fib_floor <= prev[W-1:0];
            bus.remainder <= tgt - prev[W-1:0];
`endif
          end
        end
        DONE: begin
          bus.done <= 1'b0;
          state    <= IDLE;
        end
        default: begin
          bus.busy <= 1'b0;
          bus.done <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule
